// File: rtl/configurable_seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// Define CONFIGURABLE_SEQ_DIV_DBZ_EN to short-circuit zero divisors with a div_by_zero flag.
module configurable_seq_div #(
    parameter int WIDTH       = 8,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start, operands not yet latched
    // CALC  | one restoring step per cycle on magnitudes
    // FIX   | sign correction, results written
    // DONE  | done pulse, results valid
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

`ifdef CONFIGURABLE_SEQ_DIV_DBZ_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic             neg_q;
    logic             neg_r;

    logic             eff_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        eff_signed = SIGNED_MODE | sign_mode;
        a_mag      = (eff_signed && a[WIDTH-1]) ? -a : a;
        b_mag      = (eff_signed && b[WIDTH-1]) ? -b : b;
        trial      = {rem_r, quo_r[WIDTH-1]};
        ge         = (trial >= {1'b0, div_r});
        // when ge holds the difference is below 2^WIDTH, so the top bit can be dropped
        diff       = trial[WIDTH-1:0] - div_r;
        rem_next   = ge ? diff : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            div_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (DBZ_EN && (b == '0)) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quo_r <= a_mag;
                            rem_r <= '0;
                            div_r <= b_mag;
                            neg_q <= eff_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= eff_signed & a[WIDTH-1];
                            cnt   <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo_r <= {quo_r[WIDTH-2:0], ge};
                    rem_r <= rem_next;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    quotient    <= neg_q ? -quo_r : quo_r;
                    remainder   <= neg_r ? -rem_r : rem_r;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/configurable_seq_div.md
CONFIGURABLE_SEQ_DIV -- requirements
Module: configurable_seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8: dividend, divisor, quotient and remainder width.
REQ-002 SHALL have parameter SIGNED_MODE, default 0: 1 forces signed division; 0 defers to sign_mode.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: request a division; accepted only in IDLE.
REQ-006 SHALL have port a, input, WIDTH: dividend.
REQ-007 SHALL have port b, input, WIDTH: divisor.
REQ-008 SHALL have port sign_mode, input, 1: 1 means signed, 0 means unsigned; effective signed = SIGNED_MODE or sign_mode.
REQ-009 SHALL have port busy, output, 1: high in CALC and FIX.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when results are valid.
REQ-011 SHALL have port quotient, output, WIDTH: registered quotient.
REQ-012 SHALL have port remainder, output, WIDTH: registered remainder.
REQ-013 SHALL have port div_by_zero, output, 1: zero-divisor flag; valid with done.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX and DONE as a registered FSM.
REQ-015 SHALL, at edge N with start=1 in IDLE, latch a, b and effective sign into internal registers and enter CALC; later changes on a, b or sign_mode have no effect.
REQ-016 SHALL run one restoring-division step per cycle on unsigned magnitudes in CALC: WIDTH steps, on edges N+1 to N+WIDTH, then enter FIX.
REQ-017 SHALL apply sign correction in FIX and write quotient and remainder at edge N+WIDTH+1, entering DONE; done=1 for exactly that one cycle, then the FSM returns to IDLE.
REQ-018 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next result write.
REQ-019 SHALL ignore start in CALC, FIX and DONE; there is no queuing.
REQ-020 SHALL compute unsigned results as quotient = floor(a/b) and remainder = a mod b.
REQ-021 SHALL compute signed results in two's complement:
- quotient truncates toward zero;
- remainder takes the sign of the dividend;
- magnitudes use WIDTH-bit unsigned, so abs(-2^(WIDTH-1)) is representable.
REQ-022 SHALL return quotient = -2^(WIDTH-1) (wrapped) and remainder = 0 for signed -2^(WIDTH-1) / -1, with no flag.
REQ-023 SHALL treat a zero dividend normally: quotient 0, remainder 0, at full latency.

Reset
REQ-024 SHALL, on rst_n low (asynchronous, any state including mid-CALC), force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-025 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro CONFIGURABLE_SEQ_DIV_DBZ_EN to control zero-divisor handling.
REQ-027 SHALL, when the macro is defined, handle a start with b == 0 as follows:
- go from IDLE directly to DONE at edge N;
- write quotient = all ones, remainder = a, div_by_zero = 1;
- done is high in the cycle after edge N;
- div_by_zero clears on the next result write.
REQ-028 SHALL, when the macro is undefined, tie div_by_zero to 0 and run a zero divisor through the full path at normal latency. Unsigned result: quotient all ones, remainder = a. Signed result: the normal sign correction applied to those magnitudes.

Verification
REQ-029 SHALL cover unsigned, WIDTH=8, a=100, b=7, start at edge N -> busy during N+1..N+WIDTH+1, done at edge N+9, quotient=14, remainder=2.
REQ-030 SHALL cover signed (sign_mode=1) a=0xF9 (-7), b=0x02 -> quotient=0xFD (-3), remainder=0xFF (-1); and SIGNED_MODE=1, sign_mode=0, a=0x07, b=0xFE -> quotient=0xFD, remainder=0x01.
REQ-031 SHALL cover signed a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0.
REQ-032 SHALL cover macro defined, a=0x2A, b=0 -> done one cycle after start, quotient=0xFF, remainder=0x2A, div_by_zero=1; macro undefined, unsigned -> same quotient and remainder at full latency, div_by_zero=0.
REQ-033 SHALL cover start pulsed mid-CALC with new operands -> ignored, first result unchanged; rst_n low mid-CALC -> busy=0, done=0, all outputs 0 immediately, no done pulse afterward.
